// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - byte-side handshake bundle of the UART receiver
interface uart_rx_if #(
  parameter int FIFO_DEPTH = 16
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]    rx_data;
  logic          rx_data_vld;
  logic          rx_data_rd;
  logic          rx_frame_err;
  logic          rx_overflow;
  logic [CW-1:0] rx_fifo_cnt;

  // Receiver side: produces bytes and status, consumes the read strobe
  modport master (
    output rx_data, rx_data_vld, rx_frame_err, rx_overflow, rx_fifo_cnt,
    input  rx_data_rd
  );

  // Consumer side: reads bytes and status, drives the read strobe
  modport slave (
    input  rx_data, rx_data_vld, rx_frame_err, rx_overflow, rx_fifo_cnt,
    output rx_data_rd
  );
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with show-ahead FIFO; define UART_RX_MAJORITY_EN for 2-of-3 sampling
module uart_rx #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] uart_bit_width,
  input  logic        rx,
  uart_rx_if.master   bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_n;
  logic [15:0]   width_cnt, width_n;
  logic [3:0]    bit_cnt, bit_n;
  logic [7:0]    shift_reg, shift_n;
  logic          push, ferr_n;
  logic          rx_meta, rx_s, rx_prev, sample;
  logic [15:0]   half;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic          empty, full, pop, push_ok, ovf_n;
  logic          ferr_q, ovf_q;

  assign half = {1'b0, uart_bit_width[15:1]};

  // Two-flop synchronizer for the asynchronous line, idle-high reset
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] rx_hist;
  logic [2:0] rx_h;

  // Keep the two previous synchronized samples for majority voting
  always_ff @(posedge clk) begin
    if (rst) rx_hist <= 2'b11;
    else     rx_hist <= {rx_hist[0], rx_s};
  end

  assign rx_h    = {rx_hist, rx_s};
  assign rx_prev = rx_hist[0];
  assign sample  = (rx_h[0] & rx_h[1]) | (rx_h[0] & rx_h[2]) | (rx_h[1] & rx_h[2]);
`else
  // Previous synchronized sample for falling-edge detection
  always_ff @(posedge clk) begin
    if (rst) rx_prev <= 1'b1;
    else     rx_prev <= rx_s;
  end

  assign sample = rx_s;
`endif

  // Frame FSM state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      width_cnt <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else begin
      state     <= state_n;
      width_cnt <= width_n;
      bit_cnt   <= bit_n;
      shift_reg <= shift_n;
    end
  end

  // Bit timing, sampling and frame decoding; push/frame error decided at the stop sample
  always_comb begin
    state_n = state;
    width_n = width_cnt;
    bit_n   = bit_cnt;
    shift_n = shift_reg;
    push    = 1'b0;
    ferr_n  = 1'b0;
    case (state)
      IDLE: begin
        width_n = '0;
        bit_n   = '0;
        if (rx_prev && !rx_s) state_n = START;
      end
      START: begin
        if (width_cnt == half) begin
          width_n = '0;
          state_n = sample ? IDLE : DATA;
        end else begin
          width_n = width_cnt + 16'd1;
        end
      end
      DATA: begin
        if (width_cnt == uart_bit_width) begin
          width_n = '0;
          shift_n = {sample, shift_reg[7:1]};
          bit_n   = bit_cnt + 4'd1;
          if (bit_cnt == 4'd7) state_n = STOP;
        end else begin
          width_n = width_cnt + 16'd1;
        end
      end
      STOP: begin
        if (width_cnt == uart_bit_width) begin
          width_n = '0;
          state_n = IDLE;
          if (sample) push = 1'b1;
          else        ferr_n = 1'b1;
        end else begin
          width_n = width_cnt + 16'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(FIFO_DEPTH));
  assign pop     = bus.rx_data_rd && !empty;
  assign push_ok = push && (!full || pop);
  assign ovf_n   = push && full && !pop;

  // FIFO storage write; contents need no reset since reads are gated by occupancy
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= shift_reg;
  end

  // FIFO pointers, occupancy and registered status pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ferr_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      cnt    <= cnt + CW'(push_ok) - CW'(pop);
      ferr_q <= ferr_n;
      ovf_q  <= ovf_n;
    end
  end

  assign bus.rx_data      = empty ? 8'h00 : mem[rd_ptr];
  assign bus.rx_data_vld  = !empty;
  assign bus.rx_fifo_cnt  = cnt;
  assign bus.rx_frame_err = ferr_q;
  assign bus.rx_overflow  = ovf_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx
module tb_uart_rx;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] bw;
  logic        rx;

  uart_rx_if #(.FIFO_DEPTH(DEPTH)) bus ();

  uart_rx #(.FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .uart_bit_width (bw),
    .rx             (rx),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int ferr_cnt = 0;
  int ovf_cnt  = 0;
  int exp_ferr = 0;
  int exp_ovf  = 0;
  logic [7:0] model_q[$];

  // Count high cycles of the status pulses
  always @(negedge clk) begin
    if (bus.rx_frame_err === 1'b1) ferr_cnt++;
    if (bus.rx_overflow === 1'b1)  ovf_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive frame bits first..last (index 0 = start, 9 = stop), one bit period each;
  // optionally pulse the read strobe in the stop-sample cycle
  task automatic drive_bits(input logic [9:0] fr, input int first, input int last, input bit rd_stop);
    logic [9:0] f;
    f = fr;
    for (int j = first; j <= last; j++) begin
      rx = f[j];
      for (int c = 1; c <= int'(bw) + 1; c++) begin
        tick();
        if (rd_stop && j == 9) bus.rx_data_rd = (c == int'(bw) / 2 + 3);
      end
    end
    bus.rx_data_rd = 1'b0;
  endtask

  // Reference model: good stop pushes unless full (a same-cycle pop frees a slot)
  task automatic model_frame(input logic [7:0] d, input bit stop, input bit rd_stop);
    if (!stop) begin
      exp_ferr++;
    end else begin
      if (rd_stop && model_q.size() > 0) void'(model_q.pop_front());
      if (model_q.size() < DEPTH) model_q.push_back(d);
      else exp_ovf++;
    end
  endtask

  task automatic send(input logic [7:0] d, input bit stop = 1'b1, input bit rd_stop = 1'b0);
    drive_bits({stop, d, 1'b0}, 0, 9, rd_stop);
    model_frame(d, stop, rd_stop);
  endtask

  task automatic idle(input int nbits);
    rx = 1'b1;
    repeat (nbits * (int'(bw) + 1)) tick();
  endtask

  task automatic pop_one(input string tag);
    check({tag, "_vld"}, bus.rx_data_vld, 1);
    check({tag, "_data"}, bus.rx_data, model_q[0]);
    void'(model_q.pop_front());
    bus.rx_data_rd = 1'b1;
    tick();
    bus.rx_data_rd = 1'b0;
  endtask

  task automatic drain(input string tag);
    check({tag, "_cnt"}, bus.rx_fifo_cnt, model_q.size());
    while (model_q.size() > 0) pop_one(tag);
    check({tag, "_empty"}, bus.rx_data_vld, 0);
    check({tag, "_ferr"}, ferr_cnt, exp_ferr);
    check({tag, "_ovf"}, ovf_cnt, exp_ovf);
  endtask

  initial begin
    logic [7:0] d;
    logic [9:0] fr;
    bit bad;

    rst = 1'b1;
    rx = 1'b1;
    bw = 16'd15;
    bus.rx_data_rd = 1'b0;
    repeat (3) tick();
    check("rst_data", bus.rx_data, 8'h00);
    check("rst_vld", bus.rx_data_vld, 0);
    check("rst_ferr", bus.rx_frame_err, 0);
    check("rst_ovf", bus.rx_overflow, 0);
    check("rst_cnt", bus.rx_fifo_cnt, 0);
    rst = 1'b0;
    idle(2);

    // Slow baud, four bytes back to back, valid rises only after the first stop sample
    bw = 16'd867;
    idle(1);
    drive_bits({1'b1, 8'h55, 1'b0}, 0, 8, 1'b0);
    check("slow_vld_before_stop", bus.rx_data_vld, 0);
    drive_bits({1'b1, 8'h55, 1'b0}, 9, 9, 1'b0);
    model_frame(8'h55, 1'b1, 1'b0);
    check("slow_vld_after_stop", bus.rx_data_vld, 1);
    check("slow_cnt1", bus.rx_fifo_cnt, 1);
    send(8'hA3);
    send(8'h00);
    send(8'hFF);
    check("slow_cnt4", bus.rx_fifo_cnt, 4);
    drain("slow");

    // False start: 3-cycle low pulse must not produce anything
    bw = 16'd15;
    idle(2);
    rx = 1'b0;
    repeat (3) tick();
    rx = 1'b1;
    repeat (7 + 4 + 3) tick();
    check("false_cnt", bus.rx_fifo_cnt, 0);
    check("false_ferr", ferr_cnt, 0);
    send(8'h5A);
    drain("false");

    // Frame error then a good byte
    send(8'h3C, 1'b0);
    idle(1);
    check("ferr_cnt_unch", bus.rx_fifo_cnt, 0);
    send(8'h81);
    drain("ferr");

    // Overflow on the 17th byte
    for (int i = 0; i <= 16; i++) send(8'(i));
    check("ovf_pulse", ovf_cnt, 1);
    check("ovf_full", bus.rx_fifo_cnt, 16);
    drain("ovf");

    // Read in the stop-sample cycle of the 17th byte avoids overflow
    for (int i = 0; i <= 15; i++) send(8'(i));
    send(8'h10, 1'b1, 1'b1);
    check("ovf_rd_full", bus.rx_fifo_cnt, 16);
    drain("ovf_rd");

    // Reset during data bit 4 of a frame
    send(8'h11);
    fr = {1'b1, 8'hA5, 1'b0};
    drive_bits(fr, 0, 4, 1'b0);
    rx = fr[5];
    repeat (12) tick();
    rst = 1'b1;
    rx = 1'b1;
    tick();
    check("mid_rst_data", bus.rx_data, 8'h00);
    check("mid_rst_vld", bus.rx_data_vld, 0);
    check("mid_rst_ferr", bus.rx_frame_err, 0);
    check("mid_rst_ovf", bus.rx_overflow, 0);
    check("mid_rst_cnt", bus.rx_fifo_cnt, 0);
    rst = 1'b0;
    model_q.delete();
    idle(2);
    send(8'hC7);
    drain("after_rst");

    // One-cycle high glitch on the mid-sample of data bit 2 of 0x00
    fr = {1'b1, 8'h00, 1'b0};
    drive_bits(fr, 0, 2, 1'b0);
    rx = 1'b0;
    for (int c = 1; c <= int'(bw) + 1; c++) begin
      tick();
      rx = (c == int'(bw) / 2 + 1);
    end
    drive_bits(fr, 4, 9, 1'b0);
`ifdef UART_RX_MAJORITY_EN
    model_frame(8'h00, 1'b1, 1'b0);
`else
    model_frame(8'h04, 1'b1, 1'b0);
`endif
    drain("glitch");

    // Randomized bytes, baud rates, gaps, frame errors and interleaved reads
    idle(1);
    for (int n = 0; n < 24; n++) begin
      bw = 16'($urandom_range(15, 40));
      d = 8'($urandom);
      bad = ($urandom_range(0, 5) == 0);
      send(d, !bad);
      if (bad || $urandom_range(0, 1) == 1) idle(1);
      if ($urandom_range(0, 2) == 0 && model_q.size() > 0) pop_one("rand_pop");
    end
    drain("rand");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver companion to the UART transmitter: recovers 8N1 frames (1 start, 8 data LSB first, 1 stop) from an asynchronous serial line at a runtime-programmable bit width. Received bytes are queued in an internal show-ahead FIFO and drained through a valid/read handshake. Sits between the board RX pin and the same byte-level logic that feeds the transmitter, sharing its `uart_bit_width` register.

## Interface
- `FIFO_DEPTH`, 16, receive FIFO entries; power of two, 2..256.
- `clk` input 1 — single system clock; all logic on rising edge.
- `rst` input 1 — synchronous, active-high reset.
- `uart_bit_width` input 16 — bit period minus one, in `clk` cycles (period = `uart_bit_width`+1); min 3; must be stable while a frame is in progress.
- `rx` input 1 — asynchronous serial line, idle high.
- `rx_data` output 8 — head-of-FIFO byte; valid when `rx_data_vld`=1.
- `rx_data_vld` output 1 — FIFO non-empty.
- `rx_data_rd` input 1 — pop head entry; ignored when `rx_data_vld`=0.
- `rx_frame_err` output 1 — 1-cycle pulse: stop bit sampled 0; byte discarded.
- `rx_overflow` output 1 — 1-cycle pulse: good byte arrived with FIFO full; byte dropped.
- `rx_fifo_cnt` output log2(FIFO_DEPTH)+1 — current FIFO occupancy.

## Operation
- `rx` passes through 2-flop synchronizer (reset value 1), then a 3-bit history `rx_h` (reset 3'b111); `rx_s` = newest synchronized sample.
- `half` = `uart_bit_width` >> 1; counter `width_cnt` is 16 bits and `bit_cnt` is 4 bits.
- States:
  - IDLE: `width_cnt`=0, `bit_cnt`=0. Falling edge of `rx_s` (previous 1, current 0) -> START.
  - START: count `width_cnt` 0..`half`. At `half`: sample=0 -> DATA, `width_cnt`<=0. Sample=1 -> IDLE (false start, no flag).
  - DATA: count 0..`uart_bit_width`. At `uart_bit_width`: shift sample into MSB of shift register (LSB-first reception), `bit_cnt`++, `width_cnt`<=0. After 8th bit -> STOP.
  - STOP: count 0..`uart_bit_width`. At `uart_bit_width`: sample=1 -> push byte (or pulse `rx_overflow` if full). Sample=0 -> pulse `rx_frame_err`. In both cases -> IDLE on the next cycle; no wait for the remainder of the stop bit.
- The IDLE falling-edge detector requires `rx_s`=1 at least once after STOP, so a line stuck low does not retrigger.
- FIFO: show-ahead, `rx_data` = mem[rd_ptr]. Push and pop in the same cycle are both honored, including when full (pop frees the slot, no overflow) and when empty (no pop; push lands).
- Pointer wrap modulo `FIFO_DEPTH`; `rx_fifo_cnt` ranges 0..`FIFO_DEPTH`.

## Timing
- Reset (synchronous, any state, mid-frame included): state IDLE, FIFO flushed.
- Reset output values: `rx_data`=8'h00, `rx_data_vld`=0, `rx_frame_err`=0, `rx_overflow`=0, `rx_fifo_cnt`=0.
- Synchronizer latency: 2 cycles from `rx` to `rx_s`.
- Stop-sample cycle S: push, `rx_frame_err`, and `rx_overflow` are all decided at S and registered.
- Cycle S+1: `rx_frame_err`/`rx_overflow` high for exactly that cycle. On a push, `rx_fifo_cnt` increments and `rx_data_vld` rises if the FIFO was empty.
- Pop: `rx_data_rd`=1 with `rx_data_vld`=1 at cycle T gives the next entry on `rx_data` at T+1.
- Sample points fall `half` + k·(`uart_bit_width`+1) cycles after the detected edge, i.e. mid-bit. Sender tolerance is ±4% at `uart_bit_width` ≥ 15.

## Configuration
- `UART_RX_MAJORITY_EN` defined: each sample (START, DATA, STOP) is the 2-of-3 majority of `rx_h`, i.e. synchronized values at the sample cycle and the two preceding cycles. Requires `uart_bit_width` ≥ 3. The falling-edge detect still uses raw `rx_s`; a 1-cycle glitch then fails the START check.
- Undefined: each sample = `rx_s` at the sample cycle. `rx_h` is not instantiated.

## Test plan
- `uart_bit_width`=867, send 0x55, 0xA3, 0x00, 0xFF back to back with no read -> `rx_data_vld` rises after first stop sample, `rx_fifo_cnt`=4, pops return 0x55, 0xA3, 0x00, 0xFF in order.
- `uart_bit_width`=15, 3-cycle low pulse on idle `rx` -> no push, no flags, state back to IDLE within `half`+4 cycles.
- `uart_bit_width`=15, frame 0x3C with stop bit 0 -> `rx_frame_err` 1-cycle pulse, `rx_fifo_cnt` unchanged; following valid 0x81 received correctly.
- `FIFO_DEPTH`=16, send 17 bytes 0x00..0x10 without reads -> 16 stored, one `rx_overflow` pulse on 17th. Repeat with `rx_data_rd` asserted on 17th stop-sample cycle -> no overflow, `rx_fifo_cnt` stays 16.
- Assert `rst` during DATA bit 4 of a frame -> all outputs at reset values next cycle. The next complete frame 0xC7 is received correctly.
- `UART_RX_MAJORITY_EN` defined, `uart_bit_width`=15, 1-cycle high glitch at the mid-sample of data bit 2 of 0x00 -> byte received as 0x00. Without the macro, the same glitch yields 0x04.
